// File: rtl/io_input_port.sv
// Key debouncer and parallel rx capture with a small CPU read port and interrupt.
// Build with RX_FIFO_EN defined to queue rx words in an RX_DEPTH-entry FIFO instead of one register.
module io_input_port #(
  parameter int KEY_N    = 4,
  parameter int DATA_W   = 16,
  parameter int DEB_CNT  = 1000,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_N-1:0]  key,
  input  logic [DATA_W-1:0] rx,
  input  logic              rx_stb,
  input  logic              rd_en,
  input  logic [1:0]        rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [KEY_N-1:0]  key_lvl,
  output logic              irq
);

  localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

  logic [KEY_N-1:0]  sync1, sync2;
  logic [CNT_W-1:0]  cnt [KEY_N];
  logic [KEY_N-1:0]  deb_done, key_fall;
  logic [KEY_N-1:0]  key_evt;
  logic              rd_rx, rd_key, rd_stat;
  logic              rx_valid;
  logic              ovf, ovf_set;
  logic [DATA_W-1:0] rx_head;
  logic [DATA_W-1:0] rd_mux;

  assign rd_rx   = rd_en && (rd_sel == 2'd0);
  assign rd_key  = rd_en && (rd_sel == 2'd1);
  assign rd_stat = rd_en && (rd_sel == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  always_comb begin
    deb_done = '0;
    key_fall = '0;
    for (int i = 0; i < KEY_N; i++) begin
      deb_done[i] = (sync2[i] != key_lvl[i]) && (cnt[i] == CNT_MAX);
      key_fall[i] = deb_done[i] && !sync2[i];
    end
  end

  // Counter only runs while the synced key disagrees with the accepted level,
  // and clears at terminal count, so it can never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_lvl <= '1;
      for (int i = 0; i < KEY_N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < KEY_N; i++) begin
        if (sync2[i] == key_lvl[i]) begin
          cnt[i] <= '0;
        end else if (deb_done[i]) begin
          cnt[i]     <= '0;
          key_lvl[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press landing on the clearing read survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_evt <= '0;
    else      key_evt <= (rd_key ? '0 : key_evt) | key_fall;
  end

`ifdef RX_FIFO_EN
  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  logic [DATA_W-1:0] mem [RX_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, push, pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rd_rx && !empty;
  assign push     = rx_stb && (!full || pop);
  assign ovf_set  = rx_stb && full && !pop;
  assign rx_valid = !empty;
  assign rx_head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= rx;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  logic [DATA_W-1:0] rx_q;

  // A strobe coinciding with a data read hands the old word out and is not an overflow.
  assign ovf_set = rx_stb && rx_valid && !rd_rx;
  assign rx_head = rx_valid ? rx_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_q     <= '0;
      rx_valid <= 1'b0;
    end else if (rx_stb) begin
      rx_q     <= rx;
      rx_valid <= 1'b1;
    end else if (rd_rx) begin
      rx_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf <= 1'b0;
    else      ovf <= (rd_stat ? 1'b0 : ovf) | ovf_set;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      2'd0: rd_mux = rx_head;
      2'd1: rd_mux[KEY_N-1:0] = key_evt;
      2'd2: rd_mux[KEY_N+1:0] = {ovf, rx_valid, key_lvl};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      irq     <= 1'b0;
    end else begin
      if (rd_en) rd_data <= rd_mux;
      irq <= (|key_evt) | rx_valid;
    end
  end

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with DEB_CNT=8; the FIFO scenarios run when RX_FIFO_EN is defined.
module tb_io_input_port;

  localparam int KEY_N  = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [KEY_N-1:0]  key;
  logic [DATA_W-1:0] rx;
  logic              rx_stb;
  logic              rd_en;
  logic [1:0]        rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic [KEY_N-1:0]  key_lvl;
  logic              irq;

  int errors = 0;
  int checks = 0;

  io_input_port #(.KEY_N(KEY_N), .DATA_W(DATA_W), .DEB_CNT(8), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .key(key), .rx(rx), .rx_stb(rx_stb),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .key_lvl(key_lvl), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [1:0] s);
    rd_en  = 1'b1;
    rd_sel = s;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    rx     = d;
    rx_stb = 1'b1;
    tick();
    rx_stb = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; key = '1; rx = '0; rx_stb = 1'b0; rd_en = 1'b0; rd_sel = 2'd0;
    #12;
    checks++; if (key_lvl !== 4'hf) begin errors++; $display("FAIL reset_key_lvl got=%h exp=f", key_lvl); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    @(negedge clk) rst = 1'b1;
    tick(2);
  endtask

  task automatic test_debounce;
    key[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (key_lvl[0] !== (k >= 10 ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL deb_lvl0 cycle=%0d got=%b", k, key_lvl[0]);
      end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL deb_irq_early got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL deb_irq got=%b exp=1", irq); end
    tick(9);
    key[0] = 1'b1;
    tick(12);
    checks++; if (key_lvl !== 4'hf) begin errors++; $display("FAIL deb_release got=%h exp=f", key_lvl); end
    do_read(2'd1);
    checks++; if (rd_data !== 16'h0001) begin errors++; $display("FAIL deb_evt got=%h exp=0001", rd_data); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL deb_irq_clear got=%b exp=0", irq); end
    do_read(2'd1);
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL deb_evt_clear got=%h exp=0000", rd_data); end
  endtask

  task automatic test_bounce;
    int bad = 0;
    for (int c = 0; c < 40; c++) begin
      key[1] = (((c / 5) % 2) == 0) ? 1'b0 : 1'b1;
      tick();
      if (key_lvl[1] !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce_lvl1 low_cycles=%0d exp=0", bad); end
    key[1] = 1'b1;
    tick(12);
    do_read(2'd1);
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL bounce_evt got=%h exp=0000", rd_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL bounce_irq got=%b exp=0", irq); end
  endtask

  task automatic test_rx;
    push(16'haaaa);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq got=%b exp=1", irq); end
    do_read(2'd0);
    checks++; if (rd_data !== 16'haaaa) begin errors++; $display("FAIL rx_data got=%h exp=aaaa", rd_data); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_drop got=%b exp=0", irq); end
    do_read(2'd2);
    checks++; if (rd_data !== 16'h000f) begin errors++; $display("FAIL rx_status got=%h exp=000f", rd_data); end
    do_read(2'd0);
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rx_empty_read got=%h exp=0000", rd_data); end
    do_read(2'd3);
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL sel3 got=%h exp=0000", rd_data); end
  endtask

`ifdef RX_FIFO_EN
  task automatic test_fifo;
    logic [DATA_W-1:0] exp;
    for (int i = 1; i <= 5; i++) push(DATA_W'(i));
    do_read(2'd2);
    checks++; if (rd_data !== 16'h003f) begin errors++; $display("FAIL fifo_ovf got=%h exp=003f", rd_data); end
    for (int i = 1; i <= 5; i++) begin
      exp = (i <= 4) ? DATA_W'(i) : '0;
      do_read(2'd0);
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL fifo_pop%0d got=%h exp=%h", i, rd_data, exp); end
    end
    do_read(2'd2);
    checks++; if (rd_data !== 16'h000f) begin errors++; $display("FAIL fifo_status_empty got=%h exp=000f", rd_data); end
    for (int i = 7; i <= 10; i++) push(DATA_W'(i));
    rx = 16'd11; rx_stb = 1'b1;
    do_read(2'd0);
    rx_stb = 1'b0;
    checks++; if (rd_data !== 16'd7) begin errors++; $display("FAIL fifo_full_pushpop got=%h exp=0007", rd_data); end
    do_read(2'd2);
    checks++; if (rd_data !== 16'h001f) begin errors++; $display("FAIL fifo_full_noovf got=%h exp=001f", rd_data); end
    for (int i = 8; i <= 11; i++) begin
      do_read(2'd0);
      checks++; if (rd_data !== DATA_W'(i)) begin errors++; $display("FAIL fifo_drain got=%h exp=%h", rd_data, DATA_W'(i)); end
    end
    rx = 16'h0009; rx_stb = 1'b1;
    do_read(2'd0);
    rx_stb = 1'b0;
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL fifo_empty_pushpop got=%h exp=0000", rd_data); end
    do_read(2'd0);
    checks++; if (rd_data !== 16'h0009) begin errors++; $display("FAIL fifo_empty_pushed got=%h exp=0009", rd_data); end
  endtask
`else
  task automatic test_overflow;
    push(16'haaaa);
    push(16'h1234);
    do_read(2'd2);
    checks++; if (rd_data !== 16'h003f) begin errors++; $display("FAIL ovf_set got=%h exp=003f", rd_data); end
    do_read(2'd0);
    checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL ovf_data got=%h exp=1234", rd_data); end
    do_read(2'd2);
    checks++; if (rd_data !== 16'h000f) begin errors++; $display("FAIL ovf_clear got=%h exp=000f", rd_data); end
  endtask
`endif

  task automatic test_back_to_back;
    push(16'h5555);
    rx = 16'h6666; rx_stb = 1'b1;
    do_read(2'd0);
    rx_stb = 1'b0;
    checks++; if (rd_data !== 16'h5555) begin errors++; $display("FAIL b2b_old got=%h exp=5555", rd_data); end
    do_read(2'd2);
    checks++; if (rd_data !== 16'h001f) begin errors++; $display("FAIL b2b_status got=%h exp=001f", rd_data); end
    do_read(2'd0);
    checks++; if (rd_data !== 16'h6666) begin errors++; $display("FAIL b2b_new got=%h exp=6666", rd_data); end
  endtask

  task automatic test_reset_mid;
    key[2] = 1'b0;
    tick(6);
    push(16'h7777);
    do_read(2'd2);
    checks++; if (rd_data !== 16'h001f) begin errors++; $display("FAIL rmid_pre got=%h exp=001f", rd_data); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rmid_pre_irq got=%b exp=1", irq); end
    #2 rst = 1'b0;
    #1;
    checks++; if (key_lvl !== 4'hf) begin errors++; $display("FAIL rmid_key_lvl got=%h exp=f", key_lvl); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rmid_rd_data got=%h exp=0000", rd_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_irq got=%b exp=0", irq); end
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (key_lvl[2] !== (k >= 10 ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL rmid_lvl2 cycle=%0d got=%b", k, key_lvl[2]);
      end
    end
    do_read(2'd0);
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rmid_rx got=%h exp=0000", rd_data); end
    do_read(2'd2);
    checks++; if (rd_data !== 16'h000b) begin errors++; $display("FAIL rmid_status got=%h exp=000b", rd_data); end
    key[2] = 1'b1;
    tick(12);
    do_read(2'd1);
    checks++; if (rd_data !== 16'h0004) begin errors++; $display("FAIL rmid_evt got=%h exp=0004", rd_data); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_bounce();
    test_rx();
`ifdef RX_FIFO_EN
    test_fifo();
`else
    test_overflow();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
IO_INPUT_PORT -- requirements
Module: io_input_port

Interface
REQ-001 The block SHALL have parameter KEY_N, default 4, giving the number of key channels.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the rx word width.
REQ-003 The block SHALL have parameter DEB_CNT, default 1000, giving the clk cycles a key must be stable before it is accepted.
REQ-004 The block SHALL have parameter RX_DEPTH, default 4, power of two, giving the rx FIFO depth (used only with RX_FIFO_EN).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port key, input, KEY_N bits: raw asynchronous keys, active-low, 1 = released.
REQ-008 The block SHALL have port rx, input, DATA_W bits: parallel input word, sampled only on rx_stb.
REQ-009 The block SHALL have port rx_stb, input, 1 bit: capture strobe, synchronous to clk.
REQ-010 The block SHALL have port rd_en, input, 1 bit: CPU read request, one-cycle pulse.
REQ-011 The block SHALL have port rd_sel, input, 2 bits: read register select.
REQ-012 The block SHALL have port rd_data, output, DATA_W bits: registered read data.
REQ-013 The block SHALL have port key_lvl, output, KEY_N bits: debounced key levels.
REQ-014 The block SHALL have port irq, output, 1 bit: registered interrupt request.

Function
REQ-015 Each key bit SHALL pass through a 2-flop synchroniser before debounce.
REQ-016 A per-key counter SHALL increment while the synced key differs from key_lvl and clear when they are equal.
REQ-017 When a key's counter reaches DEB_CNT-1, key_lvl for that key SHALL take the synced value next cycle and the counter SHALL clear.
REQ-018 Counter width SHALL be clog2(DEB_CNT); the counter SHALL NOT wrap.
REQ-019 A key_lvl 1->0 transition SHALL set sticky flag key_evt[i].
REQ-020 A read with rd_sel=1 SHALL clear all key_evt bits that were already set; a press landing in the same cycle as the clear SHALL survive (set wins).
REQ-021 rx_stb high SHALL capture rx and set rx_valid the next cycle.
REQ-022 Without FIFO, rx_stb while rx_valid=1 SHALL overwrite the data and set sticky ovf.
REQ-023 rd_en SHALL return rd_data one cycle later, held until the next rd_en: sel 0 = rx data with rx_valid cleared (0 if rx_valid=0); sel 1 = key_evt zero-extended; sel 2 = {ovf, rx_valid, key_lvl} in LSBs, then ovf cleared; sel 3 = 0.
REQ-024 rx_stb and an rd_sel=0 read in the same cycle SHALL return the old word and leave rx_valid=1 holding the new word, with no ovf.
REQ-025 irq SHALL equal the registered (|key_evt) | rx_valid, one cycle after the source changes.

Reset
REQ-026 rst low SHALL immediately force key_lvl and synchronisers to all 1s, and counters, key_evt, rx data, rx_valid, ovf, rd_data, irq and FIFO pointers to 0.
REQ-027 A reset asserted mid-debounce or mid-FIFO SHALL discard all progress; after release, keys need a full DEB_CNT of stability.

Configuration
REQ-028 With macro RX_FIFO_EN defined, rx data SHALL be held in a RX_DEPTH-entry FIFO: push on rx_stb, pop on an rd_sel=0 read, rx_valid = not empty.
REQ-029 With RX_FIFO_EN: a push when full SHALL be dropped and set ovf; a pop when empty SHALL return 0 with pointers unchanged; simultaneous push and pop when full SHALL perform both; simultaneous push and pop when empty SHALL return 0 and push.
REQ-030 Without RX_FIFO_EN, a single-entry register SHALL apply (REQ-021 to REQ-024), and RX_DEPTH SHALL be ignored.

Verification
REQ-031 DEB_CNT=8; key[0] low 20 cycles -> key_lvl[0]=0 exactly 8 cycles after the synced edge, key_evt[0]=1, irq=1 the following cycle.
REQ-032 key[1] bouncing 5-cycle pulses for 40 cycles -> key_lvl[1] stays 1 and no event is set.
REQ-033 rx=16'haaaa with rx_stb, then rd_sel=0 read -> rd_data=16'haaaa one cycle later, rx_valid=0, and irq drops if no key events are pending.
REQ-034 No FIFO: rx_stb with 16'haaaa then 16'h1234, then rd_sel=2 -> ovf bit 1; rd_sel=0 -> 16'h1234; second rd_sel=2 read -> ovf bit 0.
REQ-035 RX_FIFO_EN, RX_DEPTH=4: 5 pushes 1..5 -> ovf=1; 4 reads return 1,2,3,4; 5th read returns 0.
REQ-036 rst pulled low mid-debounce and with the FIFO non-empty -> all outputs at reset values immediately; after release, key needs a full DEB_CNT and FIFO reads return 0.
